el2_regfile_snapshot: RTL and testbench

//  Consumer of the register-file exposure bundle (el2_regfile_if, veer_rf_sink modport).
//  On request, atomically captures the exposed GPRs/CSRs into a local buffer in one cycle.

---
 rtl/el2_regfile_snapshot_if.sv | 21 ++
 rtl/el2_regfile_snapshot.sv | 135 +++++++++++++
 tb/tb_el2_regfile_snapshot.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/el2_regfile_snapshot_if.sv
// Register-file exposure bundle: every architecturally visible GPR/CSR the core
// publishes for trace and debug consumers, 32 bits each.
interface el2_regfile_if;
  logic [31:0] ra, sp, fp;
  logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic [31:0] pc, npc;
  logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip;
  logic [31:0] mcyclel, mcycleh, minstretl, minstreth, mrac;

  modport veer_rf_source (
    output ra, sp, fp, a0, a1, a2, a3, a4, a5, a6, a7, pc, npc,
           mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip,
           mcyclel, mcycleh, minstretl, minstreth, mrac
  );

  modport veer_rf_sink (
    input ra, sp, fp, a0, a1, a2, a3, a4, a5, a6, a7, pc, npc,
          mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip,
          mcyclel, mcycleh, minstretl, minstreth, mrac
  );
endinterface

// File: rtl/el2_regfile_snapshot.sv
// Captures the exposed register file into a local buffer in a single cycle and
// streams it out word by word over a valid/ready channel, optionally headed.
module el2_regfile_snapshot #(
  parameter int INCLUDE_CSR = 1,
  parameter int HDR_EN      = 1,
  parameter int DROP_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  el2_regfile_if.veer_rf_sink   i_rf,
  input  logic                  i_snap_req,
  input  logic                  i_snap_abort,
  output logic                  o_snap_busy,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [31:0]           o_out_data,
  output logic [4:0]            o_out_idx,
  output logic                  o_out_last,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  localparam int         NRF      = 11 + 15 * INCLUDE_CSR;
  localparam int         NW       = HDR_EN + NRF;
  localparam logic [4:0] LAST_IDX = 5'(NW - 1);

  typedef enum logic {IDLE, STREAM} stateT;

  stateT                 r_state, w_stateNxt;
  logic [31:0]           w_capWords [26];
  logic [31:0]           r_buf [NRF];
  logic [7:0]            r_seq;
  logic [DROP_CNT_W-1:0] r_dropCnt;
  logic [4:0]            r_idx;
  logic [31:0]           r_data;
  logic                  r_last;
  logic                  w_capture, w_advance, w_clear, w_drop, w_handshake;
  logic [4:0]            w_nextIdx;
  logic [31:0]           w_nextWord, w_firstWord;

  assign w_capWords = '{i_rf.ra, i_rf.sp, i_rf.fp,
                        i_rf.a0, i_rf.a1, i_rf.a2, i_rf.a3, i_rf.a4, i_rf.a5, i_rf.a6, i_rf.a7,
                        i_rf.pc, i_rf.npc, i_rf.mstatus, i_rf.mie, i_rf.mtvec, i_rf.mscratch,
                        i_rf.mepc, i_rf.mcause, i_rf.mtval, i_rf.mip, i_rf.mcyclel,
                        i_rf.mcycleh, i_rf.minstretl, i_rf.minstreth, i_rf.mrac};

  assign w_handshake = (r_state == STREAM) && i_out_ready;
  assign w_nextIdx   = r_idx + 5'd1;

  // The header is only ever emitted at capture time, so it is built from the live
  // sequence count rather than stored in the buffer.
  assign w_firstWord = (HDR_EN != 0) ? {8'h5A, r_seq, 8'(NRF), 8'h00} : i_rf.ra;

  always_comb begin
    w_nextWord = '0;
    for (int k = 0; k < NRF; k++) begin
      if (int'(w_nextIdx) == k + HDR_EN) w_nextWord = r_buf[k];
    end
  end

  always_comb begin
    w_stateNxt = r_state;
    w_capture  = 1'b0;
    w_advance  = 1'b0;
    w_clear    = 1'b0;
    w_drop     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_snap_req && !i_snap_abort) begin
          w_capture  = 1'b1;
          w_stateNxt = STREAM;
        end
      end
      STREAM: begin
        if (i_snap_abort) begin
          w_clear    = 1'b1;
          w_stateNxt = IDLE;
        end else if (w_handshake && r_last) begin
          // A request landing on the final handshake chains straight into a new snapshot.
          if (i_snap_req) begin
            w_capture = 1'b1;
          end else begin
            w_clear    = 1'b1;
            w_stateNxt = IDLE;
          end
        end else begin
          w_advance = w_handshake;
          w_drop    = i_snap_req;
        end
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_seq     <= '0;
      r_dropCnt <= '0;
    end else begin
      r_state <= w_stateNxt;
      if (w_capture) begin
        r_idx  <= '0;
        r_data <= w_firstWord;
        r_last <= (LAST_IDX == 5'd0);
        r_seq  <= r_seq + 8'd1;
      end else if (w_advance) begin
        r_idx  <= w_nextIdx;
        r_data <= w_nextWord;
        r_last <= (w_nextIdx == LAST_IDX);
      end else if (w_clear) begin
        r_idx  <= '0;
        r_data <= '0;
        r_last <= 1'b0;
      end
      if (w_drop && (r_dropCnt != '1)) r_dropCnt <= r_dropCnt + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int k = 0; k < NRF; k++) r_buf[k] <= w_capWords[k];
    end
  end

  assign o_snap_busy = (r_state == STREAM);
  assign o_out_valid = (r_state == STREAM);
  assign o_out_data  = r_data;
  assign o_out_idx   = r_idx;
  assign o_out_last  = r_last;
  assign o_drop_cnt  = r_dropCnt;

endmodule

// File: tb/tb_el2_regfile_snapshot.sv
// Self-checking bench for el2_regfile_snapshot: directed and randomized steps
// checked against a queue-based model of the expected word stream.
module tb_el2_regfile_snapshot;

  logic        clk;
  logic        rst_l;
  logic [31:0] rfVals [26];

  logic        snapReq, snapAbort, outReady;
  logic        busy, valid, last;
  logic [31:0] data;
  logic [4:0]  idx;
  logic [15:0] drop;

  logic        satBusy, satValid, satLast;
  logic [31:0] satData;
  logic [4:0]  satIdx;
  logic [1:0]  dropSat;

  logic        minReq, minAbort, minReady;
  logic        minBusy, minValid, minLast;
  logic [31:0] minData;
  logic [4:0]  minIdx;
  logic [15:0] minDrop;

  int          tests, fails;

  // Model: the words still to be delivered for the snapshot in flight.
  logic [31:0] mWords [$];
  bit          mActive;
  int          mIdx, mSeq, mDrops;

  el2_regfile_if rfBus ();

  assign rfBus.ra = rfVals[0];         assign rfBus.sp = rfVals[1];
  assign rfBus.fp = rfVals[2];         assign rfBus.a0 = rfVals[3];
  assign rfBus.a1 = rfVals[4];         assign rfBus.a2 = rfVals[5];
  assign rfBus.a3 = rfVals[6];         assign rfBus.a4 = rfVals[7];
  assign rfBus.a5 = rfVals[8];         assign rfBus.a6 = rfVals[9];
  assign rfBus.a7 = rfVals[10];        assign rfBus.pc = rfVals[11];
  assign rfBus.npc = rfVals[12];       assign rfBus.mstatus = rfVals[13];
  assign rfBus.mie = rfVals[14];       assign rfBus.mtvec = rfVals[15];
  assign rfBus.mscratch = rfVals[16];  assign rfBus.mepc = rfVals[17];
  assign rfBus.mcause = rfVals[18];    assign rfBus.mtval = rfVals[19];
  assign rfBus.mip = rfVals[20];       assign rfBus.mcyclel = rfVals[21];
  assign rfBus.mcycleh = rfVals[22];   assign rfBus.minstretl = rfVals[23];
  assign rfBus.minstreth = rfVals[24]; assign rfBus.mrac = rfVals[25];

  el2_regfile_snapshot dut (
    .clk(clk), .rst_l(rst_l), .i_rf(rfBus),
    .i_snap_req(snapReq), .i_snap_abort(snapAbort), .o_snap_busy(busy),
    .o_out_valid(valid), .i_out_ready(outReady), .o_out_data(data),
    .o_out_idx(idx), .o_out_last(last), .o_drop_cnt(drop)
  );

  el2_regfile_snapshot #(.DROP_CNT_W(2)) dutSat (
    .clk(clk), .rst_l(rst_l), .i_rf(rfBus),
    .i_snap_req(snapReq), .i_snap_abort(snapAbort), .o_snap_busy(satBusy),
    .o_out_valid(satValid), .i_out_ready(outReady), .o_out_data(satData),
    .o_out_idx(satIdx), .o_out_last(satLast), .o_drop_cnt(dropSat)
  );

  el2_regfile_snapshot #(.INCLUDE_CSR(0), .HDR_EN(0)) dutMin (
    .clk(clk), .rst_l(rst_l), .i_rf(rfBus),
    .i_snap_req(minReq), .i_snap_abort(minAbort), .o_snap_busy(minBusy),
    .o_out_valid(minValid), .i_out_ready(minReady), .o_out_data(minData),
    .o_out_idx(minIdx), .o_out_last(minLast), .o_drop_cnt(minDrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int satMin(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelSnap();
    mWords.delete();
    mWords.push_back({8'h5A, 8'(mSeq), 8'd26, 8'h00});
    for (int k = 0; k < 26; k++) mWords.push_back(rfVals[k]);
    mSeq++;
    mIdx    = 0;
    mActive = 1'b1;
  endtask

  task automatic modelReset();
    mWords.delete();
    mActive = 1'b0;
    mIdx    = 0;
    mSeq    = 0;
    mDrops  = 0;
  endtask

  task automatic checkModel();
    checkOutput("valid", valid, mActive);
    checkOutput("busy", busy, mActive);
    checkOutput("sat_valid", satValid, mActive);
    checkOutput("drop", drop, satMin(mDrops, 65535));
    checkOutput("drop_sat", dropSat, satMin(mDrops, 3));
    if (mActive) begin
      checkOutput("idx", idx, mIdx);
      checkOutput("data", data, mWords[0]);
      checkOutput("last", last, mWords.size() == 1);
    end
  endtask

  // Drives one cycle of inputs, advances the model by the same edge, then checks.
  task automatic applyStimulus(input bit req, input bit abort, input bit ready);
    snapReq   = req;
    snapAbort = abort;
    outReady  = ready;
    if (!mActive) begin
      if (req && !abort) modelSnap();
    end else if (abort) begin
      mActive = 1'b0;
      mWords.delete();
    end else if (ready && mWords.size() == 1) begin
      if (req) modelSnap();
      else begin
        mActive = 1'b0;
        mWords.delete();
      end
    end else begin
      if (ready) begin
        void'(mWords.pop_front());
        mIdx++;
      end
      if (req) mDrops++;
    end
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && mActive; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput(tag, valid, 1'b0);
  endtask

  initial begin
    bit          pat [4];
    logic [31:0] savedPc;
    bit          pcSeen;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    tests = 0; fails = 0;
    rst_l = 1'b0;
    snapReq = 1'b0; snapAbort = 1'b0; outReady = 1'b0;
    minReq = 1'b0; minAbort = 1'b0; minReady = 1'b0;
    modelReset();
    for (int k = 0; k < 26; k++) rfVals[k] = $urandom;
    rfVals[0] = 32'h1111;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_data", data, 32'h0);
    checkOutput("rst_idx", idx, 5'd0);
    checkOutput("rst_last", last, 1'b0);
    checkOutput("rst_drop", drop, 16'h0);
    checkOutput("rst_min_valid", minValid, 1'b0);
    rst_l = 1'b1;

    // Full-rate stream with header and ra leading.
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t1_hdr", data, 32'h5A001A00);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_ra", data, 32'h1111);
    for (int i = 0; i < 25; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_idx26", idx, 5'd26);
    checkOutput("t1_last26", last, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_idle", valid, 1'b0);

    // Backpressure, with pc changing after capture.
    rfVals[11] = 32'h0000_1234;
    savedPc    = rfVals[11];
    pcSeen     = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 200 && mActive; i++) begin
      if (i == 5) rfVals[11] = 32'hDEAD;
      applyStimulus(1'b0, 1'b0, pat[i % 4]);
      if (mActive && mIdx == 12 && !pcSeen) begin
        checkOutput("t2_pc_held", data, savedPc);
        pcSeen = 1'b1;
      end
    end
    checkOutput("t2_done", valid, 1'b0);

    // Requests while busy are dropped and counted.
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("t3_drop3", drop, 16'd3);
    for (int p = 0; p < 2; p++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("t3_drop5", drop, 16'd5);
    checkOutput("t3_sat", dropSat, 2'd3);
    drain("t3_drain");
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t3_seq", data[23:16], 8'd3);

    // Back-to-back chaining on the final handshake, then seq wrap.
    for (int i = 0; i < 100 && mWords.size() != 1; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t4_b2b_valid", valid, 1'b1);
    checkOutput("t4_b2b_idx", idx, 5'd0);
    checkOutput("t4_b2b_seq", data[23:16], 8'd4);
    for (int i = 0; i < 20000 && mSeq < 257; i++)
      applyStimulus(!mActive || mWords.size() == 1, 1'b0, 1'b1);
    checkOutput("t4_wrap_budget", mSeq, 257);
    checkOutput("t4_wrap_hdr", data[31:16], 16'h5A00);
    drain("t4_drain");

    // Abort with a simultaneous request.
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5_idx5", idx, 5'd5);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t5_valid", valid, 1'b0);
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_idx0", idx, 5'd0);
    checkOutput("t5_drop", drop, 16'd5);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("t5_restart", idx, 5'd0);
    drain("t5_drain");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rfVals[$urandom_range(0, 25)] = $urandom;
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 1) == 1);
    end
    drain("rand_drain");

    // Asynchronous reset mid-stream.
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t6_idx10", idx, 5'd10);
    #3;
    rst_l = 1'b0;
    #1;
    checkOutput("t6_valid", valid, 1'b0);
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_data", data, 32'h0);
    checkOutput("t6_idx", idx, 5'd0);
    checkOutput("t6_last", last, 1'b0);
    checkOutput("t6_drop", drop, 16'h0);
    checkOutput("t6_drop_sat", dropSat, 2'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst_l = 1'b1;

    // Minimal build: 11 GPR words, no header.
    minReady = 1'b1;
    minReq   = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    minReq   = 1'b0;
    for (int k = 0; k < 11; k++) begin
      checkOutput("min_valid", minValid, 1'b1);
      checkOutput("min_idx", minIdx, k);
      checkOutput("min_data", minData, rfVals[k]);
      checkOutput("min_last", minLast, k == 10);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("min_idle", minValid, 1'b0);
    checkOutput("min_busy", minBusy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
